// File: rtl/video_pkg.sv
// Shared types and constants for the video pattern generator.
package video_pkg;

    localparam int COLOR_WIDTH = 8;

    typedef struct packed {
        logic [COLOR_WIDTH-1:0] r;
        logic [COLOR_WIDTH-1:0] g;
        logic [COLOR_WIDTH-1:0] b;
    } pixel_t;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_SOLID = 2'd1,
        PAT_RAMP  = 2'd2,
        PAT_LFSR  = 2'd3
    } vpg_pattern_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_GAP
    } vpg_state_e;

    // Per-bar component flags {r,g,b}, index 0 = leftmost bar.
    // Order: white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [7:0][2:0] BAR_COLORS = {
        3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
    };

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED = 32'h0000_ACE1;

    // One right-shifting Galois step.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/video_pattern_gen_if.sv
// AXI4-Stream video bus carrying {R,G,B} pixels with SOF (tuser) / EOL (tlast).
interface video_pattern_gen_if #(
    parameter int CW = video_pkg::COLOR_WIDTH
);
    logic [3*CW-1:0] tdata;
    logic            tvalid;
    logic            tready;
    logic            tlast;
    logic            tuser;

    modport master (output tdata, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/vpg_pattern_lut.sv
// Combinational pixel lookup: (pattern, x, y, solid colour, lfsr) -> {R,G,B}.
// LFSR input exists only when VPG_LFSR_EN is defined.
module vpg_pattern_lut
    import video_pkg::*;
#(
    parameter int CW       = 8,
    parameter int H_ACTIVE = 1920,
    parameter int XW       = 11,
    parameter int YW       = 11
) (
    input  vpg_pattern_e     pattern,
    input  logic [XW-1:0]    x,
    input  logic [YW-1:0]    y,
    input  logic [3*CW-1:0]  solid,
`ifdef VPG_LFSR_EN
    input  logic [3*CW-1:0]  lfsr,
`endif
    output logic [3*CW-1:0]  pixel
);

    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0]    bar;
    logic [2:0]    flags;
    logic [CW-1:0] ramp_r, ramp_g, ramp_b;

    // Select the pixel for the requested pattern; unknown codes fall back to solid.
    always_comb begin
        bar    = 3'(x / XW'(BAR_W));
        flags  = BAR_COLORS[bar];
        ramp_r = CW'(x);
        ramp_g = CW'(y);
        ramp_b = ramp_r + ramp_g;
        pixel  = solid;
        case (pattern)
            PAT_BARS:  pixel = {{CW{flags[2]}}, {CW{flags[1]}}, {CW{flags[0]}}};
            PAT_RAMP:  pixel = {ramp_r, ramp_g, ramp_b};
`ifdef VPG_LFSR_EN
            PAT_LFSR:  pixel = lfsr;
`endif
            default:   pixel = solid;
        endcase
    end

endmodule

// File: rtl/video_pattern_gen.sv
// AXI4-Stream synthetic video source (bars / solid / ramp, optional LFSR noise).
// Optional feature macro: VPG_LFSR_EN (pattern 3 = Galois LFSR noise).
// The x/y counters always point at the pixel *after* the one on the output
// register, so a transfer can load the next pixel with no bubble.
module video_pattern_gen
    import video_pkg::*;
#(
    parameter int COLOR_WIDTH = video_pkg::COLOR_WIDTH,
    parameter int H_ACTIVE    = 1920,
    parameter int V_ACTIVE    = 1080,
    parameter int FRAME_GAP   = 16
) (
    input  logic                     aclk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [1:0]               pattern_sel,
    input  logic [3*COLOR_WIDTH-1:0] solid_color,
    video_pattern_gen_if.master      m_axis_video,
    output logic                     frame_done,
    output logic [15:0]              frame_count
);

    localparam int PW       = 3 * COLOR_WIDTH;
    localparam int XW       = $clog2(H_ACTIVE);
    localparam int YW       = $clog2(V_ACTIVE);
    localparam int GW       = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
    localparam int GAP_LAST = (FRAME_GAP > 0) ? FRAME_GAP - 1 : 0;

    vpg_state_e    state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [GW-1:0] gap_cnt;
    vpg_pattern_e  pat_q;
    logic [PW-1:0] solid_q;
    logic          last_q;      // output register holds the final pixel of the frame
    logic [PW-1:0] tdata;
    logic          tvalid, tlast, tuser;

    logic          xfer, frame_end, start, load, x_end, y_end;
    vpg_pattern_e  lut_pat;
    logic [PW-1:0] lut_solid, lut_lfsr, lut_pix;

`ifdef VPG_LFSR_EN
    logic [31:0]   lfsr_q;      // state for the next pixel to be loaded
`endif

    assign xfer      = tvalid & m_axis_video.tready;
    assign frame_end = xfer & last_q;
    assign x_end     = (x == XW'(H_ACTIVE - 1));
    assign y_end     = (y == YW'(V_ACTIVE - 1));
    assign load      = start | (xfer & ~last_q);

    // Frame start: decides when pixel (0,0) of a new frame gets loaded.
    always_comb begin
        start = 1'b0;
        case (state)
            ST_IDLE:   start = enable;
            ST_GAP:    start = enable && (gap_cnt == GW'(GAP_LAST));
            ST_ACTIVE: start = frame_end && enable && (FRAME_GAP == 0);
            default:   start = 1'b0;
        endcase
    end

    // At frame start use the live inputs; afterwards the values latched for the frame.
    always_comb begin
        lut_pat   = start ? vpg_pattern_e'(pattern_sel) : pat_q;
        lut_solid = start ? solid_color : solid_q;
`ifdef VPG_LFSR_EN
        lut_lfsr  = start ? PW'(LFSR_SEED) : lfsr_q[PW-1:0];
`else
        lut_lfsr  = '0;
`endif
    end

    vpg_pattern_lut #(
        .CW       (COLOR_WIDTH),
        .H_ACTIVE (H_ACTIVE),
        .XW       (XW),
        .YW       (YW)
    ) u_lut (
        .pattern (lut_pat),
        .x       (x),
        .y       (y),
        .solid   (lut_solid),
`ifdef VPG_LFSR_EN
        .lfsr    (lut_lfsr),
`endif
        .pixel   (lut_pix)
    );

    // FSM, counters, output register and frame accounting.
    always_ff @(posedge aclk) begin
        if (reset) begin
            state       <= ST_IDLE;
            x           <= '0;
            y           <= '0;
            gap_cnt     <= '0;
            pat_q       <= PAT_BARS;
            solid_q     <= '0;
            last_q      <= 1'b0;
            tdata       <= '0;
            tvalid      <= 1'b0;
            tlast       <= 1'b0;
            tuser       <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
`ifdef VPG_LFSR_EN
            lfsr_q      <= '0;
`endif
        end else begin
            frame_done <= frame_end;
            if (frame_end)
                frame_count <= frame_count + 16'd1;

            if (start) begin
                pat_q   <= lut_pat;
                solid_q <= lut_solid;
            end

`ifdef VPG_LFSR_EN
            if (start)
                lfsr_q <= lfsr_step(LFSR_SEED);
            else if (load)
                lfsr_q <= lfsr_step(lfsr_q);
`endif

            if (load) begin
                tdata  <= lut_pix;
                tvalid <= 1'b1;
                tlast  <= x_end;
                tuser  <= (x == '0) && (y == '0);
                last_q <= x_end && y_end;
                x      <= x_end ? '0 : x + 1'b1;
                if (x_end)
                    y <= y_end ? '0 : y + 1'b1;
            end else if (xfer) begin
                tvalid <= 1'b0;
                tlast  <= 1'b0;
                tuser  <= 1'b0;
                last_q <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (start)
                        state <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    gap_cnt <= '0;
                    if (frame_end && !start)
                        state <= (FRAME_GAP > 0) ? ST_GAP : ST_IDLE;
                end
                ST_GAP: begin
                    if (gap_cnt == GW'(GAP_LAST))
                        state <= start ? ST_ACTIVE : ST_IDLE;
                    else
                        gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign m_axis_video.tdata  = tdata;
    assign m_axis_video.tvalid = tvalid;
    assign m_axis_video.tlast  = tlast;
    assign m_axis_video.tuser  = tuser;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Self-checking bench for video_pattern_gen (8x4 frame, 2-cycle gap).
module tb_video_pattern_gen;

    localparam int CW = 8;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int GAP = 2;
    localparam int NPIX = H * V;

    typedef logic [3*CW+1:0] word_t;   // {tuser, tlast, tdata}

    logic        aclk = 1'b0;
    logic        reset, enable;
    logic [1:0]  pattern_sel;
    logic [23:0] solid_color;
    logic        frame_done;
    logic [15:0] frame_count;

    int checks = 0;
    int failures = 0;

    video_pattern_gen_if #(.CW(CW)) vif ();

    video_pattern_gen #(
        .COLOR_WIDTH (CW),
        .H_ACTIVE    (H),
        .V_ACTIVE    (V),
        .FRAME_GAP   (GAP)
    ) dut (
        .aclk         (aclk),
        .reset        (reset),
        .enable       (enable),
        .pattern_sel  (pattern_sel),
        .solid_color  (solid_color),
        .m_axis_video (vif),
        .frame_done   (frame_done),
        .frame_count  (frame_count)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference pixel straight from the pattern definitions.
    function automatic word_t model_word(input int pat, input logic [23:0] solid,
                                         input int x, input int y, input int idx);
        logic [23:0] bars [8];
        video_pkg::pixel_t p;
        logic [31:0] s;
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        p = solid;
        if (pat == 0) begin
            p = bars[x / (H / 8)];
        end else if (pat == 2) begin
            p.r = 8'(x % 256);
            p.g = 8'(y % 256);
            p.b = 8'((x + y) % 256);
        end
`ifdef VPG_LFSR_EN
        else if (pat == 3) begin
            s = 32'h0000ACE1;
            for (int k = 0; k < idx; k++)
                s = (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
            p = s[23:0];
        end
`endif
        s = 32'(idx);
        return {(x == 0 && y == 0), (x == H - 1), p};
    endfunction

    task automatic build_frame(input int pat, input logic [23:0] solid, output word_t e[$]);
        e = {};
        for (int yy = 0; yy < V; yy++)
            for (int xx = 0; xx < H; xx++)
                e.push_back(model_word(pat, solid, xx, yy, yy * H + xx));
    endtask

    // Runs from #1 after an edge; collects n accepted words, checking AXIS hold rules.
    task automatic collect(input int n, input int pct, output word_t q[$]);
        int    cycles = 0;
        logic  stall = 1'b0;
        word_t held = '0;
        word_t w;
        logic  rdy;
        q = {};
        while (q.size() < n && cycles < 2000) begin
            w = {vif.tuser, vif.tlast, vif.tdata};
            if (stall) chk("hold_stable", {vif.tvalid, w}, {1'b1, held});
            rdy = ($urandom_range(99) < pct);
            vif.tready = rdy;
            if (vif.tvalid && rdy) q.push_back(w);
            stall = vif.tvalid && !rdy;
            held  = w;
            @(posedge aclk); #1;
            cycles++;
        end
        if (q.size() < n) chk("collect_timeout", 64'(q.size()), 64'(n));
    endtask

    task automatic cmp_frame(input string tag, input word_t got[$], input word_t exp[$]);
        chk({tag, "_len"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), 64'(got[i]), 64'(exp[i]));
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge aclk); #1; end
    endtask

    initial begin
        word_t got[$], got2[$], part[$], exp[$];
        int    n, hi;
        logic [23:0] sa, sb;

        reset = 1'b1; enable = 1'b0; pattern_sel = 2'd0; solid_color = '0; vif.tready = 1'b0;
        cycles(2);
        chk("rst_tvalid", 64'(vif.tvalid), 0);
        chk("rst_tlast",  64'(vif.tlast), 0);
        chk("rst_tuser",  64'(vif.tuser), 0);
        chk("rst_tdata",  64'(vif.tdata), 0);
        chk("rst_done",   64'(frame_done), 0);
        chk("rst_count",  64'(frame_count), 0);
        reset = 1'b0;
        cycles(2);
        chk("idle_tvalid", 64'(vif.tvalid), 0);

        // 1: bars, full throughput
        build_frame(0, 24'h0, exp);
        enable = 1'b1;
        collect(NPIX, 100, got);
        cmp_frame("t1_bars", got, exp);
        if (got.size() > 1) chk("t1_x1", 64'(got[1][23:0]), 64'hFFFF00);
        chk("t1_done", 64'(frame_done), 1);
        chk("t1_count", 64'(frame_count), 1);
        enable = 1'b0;
        cycles(1);
        chk("t1_done_once", 64'(frame_done), 0);
        hi = 0;
        for (int i = 0; i < 6; i++) begin hi += int'(vif.tvalid); cycles(1); end
        chk("t1_idle", 64'(hi), 0);

        // 2: bars with random backpressure
        enable = 1'b1;
        collect(NPIX, 50, got2);
        cmp_frame("t2_bp", got2, exp);
        enable = 1'b0;
        vif.tready = 1'b1;
        cycles(6);

        // 3: ramp, back-to-back frames with gap, from fresh reset
        reset = 1'b1; cycles(1); reset = 1'b0;
        chk("t3_count0", 64'(frame_count), 0);
        pattern_sel = 2'd2; enable = 1'b1;
        build_frame(2, 24'h0, exp);
        collect(NPIX, 100, got);
        cmp_frame("t3_ramp", got, exp);
        if (got.size() > 19) chk("t3_x3y2", 64'(got[2 * H + 3][23:0]), 64'h030205);
        chk("t3_count1", 64'(frame_count), 1);
        n = 0;
        while (!vif.tvalid && n < 20) begin n++; cycles(1); end
        chk("t3_gap", 64'(n), 64'(GAP));
        collect(NPIX, 100, got);
        cmp_frame("t3_ramp2", got, exp);
        chk("t3_count2", 64'(frame_count), 2);
        enable = 1'b0;
        cycles(6);

        // Solid, random colour; pattern/colour changed mid-frame must be ignored
        sa = 24'($urandom); sb = ~sa;
        pattern_sel = 2'd1; solid_color = sa; enable = 1'b1;
        build_frame(1, sa, exp);
        collect(5, 100, part);
        solid_color = sb; pattern_sel = 2'd2;
        collect(NPIX - 5, 100, got);
        got = {part, got};
        cmp_frame("solid_hold", got, exp);
        enable = 1'b0;
        cycles(6);

        // 4: enable dropped at pixel 10 -> frame completes, then idle
        pattern_sel = 2'd0; enable = 1'b1;
        build_frame(0, 24'h0, exp);
        collect(10, 100, part);
        enable = 1'b0;
        collect(NPIX - 10, 60, got);
        got = {part, got};
        cmp_frame("t4_drop", got, exp);
        vif.tready = 1'b1;
        hi = 0;
        for (int i = 0; i < 10; i++) begin hi += int'(vif.tvalid); cycles(1); end
        chk("t4_idle", 64'(hi), 0);

        // 5: reset at pixel 20, restart from (0,0)
        enable = 1'b1;
        collect(20, 100, part);
        reset = 1'b1;
        cycles(1);
        chk("t5_tvalid", 64'(vif.tvalid), 0);
        chk("t5_count", 64'(frame_count), 0);
        reset = 1'b0;
        collect(NPIX, 100, got);
        cmp_frame("t5_restart", got, exp);
        enable = 1'b0;
        cycles(6);

        // 6: pattern 3 (LFSR noise when enabled, otherwise solid)
        sa = 24'($urandom);
        pattern_sel = 2'd3; solid_color = sa; enable = 1'b1;
        build_frame(3, sa, exp);
        collect(NPIX, 70, got);
        collect(NPIX, 70, got2);
        cmp_frame("t6_f1", got, exp);
        cmp_frame("t6_f2", got2, got);
`ifdef VPG_LFSR_EN
        if (got.size() > 0) chk("t6_seed", 64'(got[0][23:0]), 64'h00ACE1);
`endif
        enable = 1'b0;
        cycles(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
